// File: rtl/ecc_pubkey_check.sv
// ecc_pubkey_check
// Checks whether an affine point (pub_x, pub_y) lies on secp256k1, i.e.
// y^2 == x^3 + 7 mod p. Out-of-range coordinates and the all-zero key are
// rejected before any arithmetic is done. All modular products share one
// bit-serial interleaved multiplier (256 cycles per product).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      request a check (honoured only while idle)
//   pub_x      affine x candidate (256 bits)
//   pub_y      affine y candidate (256 bits)
//   busy       high from the accept edge through the done cycle
//   done       one-cycle completion pulse
//   on_curve   result: point satisfies the curve equation
//   range_err  result: point rejected before arithmetic
module ecc_pubkey_check (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] pub_x,
    input  logic [255:0] pub_y,
    output logic         busy,
    output logic         done,
    output logic         on_curve,
    output logic         range_err
);

    localparam logic [255:0] P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [256:0] P257 = {1'b0, P};

    typedef enum logic [2:0] {
        IDLE,
        RANGE,
        MUL_XX,
        MUL_XXX,
        ADD7,
        MUL_YY,
        CMP
    } state_t;

    state_t       state_q, state_d;
    logic [255:0] x_q, x_d;
    logic [255:0] y_q, y_d;
    logic [255:0] t_q, t_d;
    logic [255:0] r_q, r_d;
    logic [255:0] acc_q, acc_d;
    logic [7:0]   bitCnt_q, bitCnt_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         onCurve_q, onCurve_d;
    logic         rangeErr_q, rangeErr_d;

    logic [255:0] opA;
    logic [255:0] opB;
    logic [7:0]   bitIdx;
    logic         bBit;
    logic [256:0] dblFull;
    logic [255:0] dblRed;
    logic [256:0] addFull;
    logic [255:0] addRed;
    logic [255:0] stepResult;
    logic [255:0] sum7;
    logic [255:0] sum7Red;
    logic         inputBad;

    // One step of the interleaved multiplier: double the accumulator, then
    // add operand a when the current bit of b (scanned MSB-first) is set.
    // Both operands of each addition are below p, so one conditional
    // subtract keeps the accumulator reduced. When a 257-bit value is >= p
    // its reduced form fits in 256 bits, so the subtract is done at 256 bits.
    always_comb begin
        opA = x_q;
        opB = x_q;
        case (state_q)
            MUL_XXX: opA = t_q;
            MUL_YY: begin
                opA = y_q;
                opB = y_q;
            end
            default: ;
        endcase
        bitIdx     = 8'd255 - bitCnt_q;
        bBit       = opB[bitIdx];
        dblFull    = {acc_q, 1'b0};
        dblRed     = (dblFull >= P257) ? (dblFull[255:0] - P) : dblFull[255:0];
        addFull    = {1'b0, dblRed} + {1'b0, opA};
        addRed     = (addFull >= P257) ? (addFull[255:0] - P) : addFull[255:0];
        stepResult = bBit ? addRed : dblRed;
        // t < p and p + 7 < 2^256, so the +7 never overflows 256 bits.
        sum7       = t_q + 256'd7;
        sum7Red    = (sum7 >= P) ? (sum7 - P) : sum7;
        inputBad   = (x_q >= P) || (y_q >= P) || ((x_q == '0) && (y_q == '0));
    end

    // Next-state and datapath control. Each multiply runs 256 steps; the
    // finished product lands in t (x^2, then x^3) or stays in acc (y^2).
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        t_d        = t_q;
        r_d        = r_q;
        acc_d      = acc_q;
        bitCnt_d   = bitCnt_q;
        done_d     = 1'b0;
        onCurve_d  = onCurve_q;
        rangeErr_d = rangeErr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d        = pub_x;
                    y_d        = pub_y;
                    onCurve_d  = 1'b0;
                    rangeErr_d = 1'b0;
                    state_d    = RANGE;
                end
            end
            RANGE: begin
                if (inputBad) begin
                    rangeErr_d = 1'b1;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end else begin
                    acc_d    = '0;
                    bitCnt_d = '0;
                    state_d  = MUL_XX;
                end
            end
            MUL_XX, MUL_XXX: begin
                acc_d    = stepResult;
                bitCnt_d = bitCnt_q + 8'd1;
                if (bitCnt_q == 8'd255) begin
                    t_d     = stepResult;
                    acc_d   = '0;
                    state_d = (state_q == MUL_XX) ? MUL_XXX : ADD7;
                end
            end
            ADD7: begin
                r_d      = sum7Red;
                acc_d    = '0;
                bitCnt_d = '0;
                state_d  = MUL_YY;
            end
            MUL_YY: begin
                acc_d    = stepResult;
                bitCnt_d = bitCnt_q + 8'd1;
                if (bitCnt_q == 8'd255) begin
                    state_d = CMP;
                end
            end
            CMP: begin
                onCurve_d = (r_q == acc_q);
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Busy covers every non-idle cycle plus the done cycle itself.
        busy_d = (state_d != IDLE) || done_d;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            t_q        <= '0;
            r_q        <= '0;
            acc_q      <= '0;
            bitCnt_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            onCurve_q  <= 1'b0;
            rangeErr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            t_q        <= t_d;
            r_q        <= r_d;
            acc_q      <= acc_d;
            bitCnt_q   <= bitCnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            onCurve_q  <= onCurve_d;
            rangeErr_q <= rangeErr_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign on_curve  = onCurve_q;
    assign range_err = rangeErr_q;

endmodule

// File: tb/tb_ecc_pubkey_check.sv
// tb_ecc_pubkey_check
// Self-checking bench for ecc_pubkey_check: a table of known points, a few
// random points judged by a plain-arithmetic curve model, and hand-written
// sequences for ignored restarts, mid-run reset and back-to-back starts.
module tb_ecc_pubkey_check;

    localparam logic [255:0] P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [255:0] GX =
        256'h79BE667E_F9DCBBAC_55A06295_CE870B07_029BFCDB_2DCE28D9_59F2815B_16F81798;
    localparam logic [255:0] GY =
        256'h483ADA77_26A3C465_5DA4FBFC_0E1108A8_FD17B448_A6855419_9C47D08F_FB10D4B8;
    localparam logic [255:0] BETA =
        256'h7AE96A2B_657C0710_6E64479E_AC3434E9_9CF04975_12F58995_C1396C28_719501EE;
    localparam int FULL_LAT = 771;
    localparam int REJ_LAT  = 1;

    logic         clk;
    logic         rst;
    logic         start;
    logic [255:0] pubX;
    logic [255:0] pubY;
    logic         busy;
    logic         done;
    logic         onCurve;
    logic         rangeErr;

    int checks;
    int fails;

    typedef struct {
        string        name;
        logic [255:0] x;
        logic [255:0] y;
        logic         expOn;
        logic         expErr;
        int           expLat;
    } vec_t;

    ecc_pubkey_check dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pub_x     (pubX),
        .pub_y     (pubY),
        .busy      (busy),
        .done      (done),
        .on_curve  (onCurve),
        .range_err (rangeErr)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Curve membership straight from the equation, using wide arithmetic.
    function automatic logic refOnCurve(input logic [255:0] x, input logic [255:0] y);
        logic [511:0] pp, xw, yw, lhs, rhs;
        pp  = {256'd0, P};
        xw  = {256'd0, x};
        yw  = {256'd0, y};
        rhs = (xw * xw) % pp;
        rhs = (rhs * xw) % pp;
        rhs = (rhs + 512'd7) % pp;
        lhs = (yw * yw) % pp;
        return lhs == rhs;
    endfunction

    function automatic logic refRangeErr(input logic [255:0] x, input logic [255:0] y);
        return (x >= P) || (y >= P) || ((x == '0) && (y == '0));
    endfunction

    function automatic logic [255:0] mulModP(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] m;
        m = ({256'd0, a} * {256'd0, b}) % {256'd0, P};
        return m[255:0];
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom)};
        return r;
    endfunction

    function automatic vec_t modelVec(input string name, input logic [255:0] x,
                                      input logic [255:0] y);
        vec_t v;
        v.name   = name;
        v.x      = x;
        v.y      = y;
        v.expErr = refRangeErr(x, y);
        v.expOn  = v.expErr ? 1'b0 : refOnCurve(x, y);
        v.expLat = v.expErr ? REJ_LAT : FULL_LAT;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Counts rising edges until done is seen (sampled 1 time unit after
    // each edge); returns -1 if the budget runs out.
    task automatic waitDone(input int limit, output int lat);
        lat = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    // Presents a start with the given operands on edge E0, then waits for done.
    task automatic applyStimulus(input logic [255:0] x, input logic [255:0] y,
                                 output int lat, output logic busyAfterAccept);
        @(negedge clk);
        pubX  = x;
        pubY  = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        busyAfterAccept = busy;
        waitDone(FULL_LAT + 20, lat);
    endtask

    // Full check of one vector: latency, results, pulse width, result hold.
    task automatic runVector(input vec_t v);
        int   lat;
        logic bAcc;
        applyStimulus(v.x, v.y, lat, bAcc);
        checkOutput({v.name, " busy@accept"}, int'(bAcc), 1);
        checkOutput({v.name, " latency"}, lat, v.expLat);
        checkOutput({v.name, " on_curve"}, int'(onCurve), int'(v.expOn));
        checkOutput({v.name, " range_err"}, int'(rangeErr), int'(v.expErr));
        checkOutput({v.name, " busy@done"}, int'(busy), 1);
        // Scramble the inputs; held results must not follow them.
        pubX = rand256();
        pubY = rand256();
        @(posedge clk);
        #1;
        checkOutput({v.name, " done width"}, int'(done), 0);
        checkOutput({v.name, " busy after"}, int'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput({v.name, " on_curve hold"}, int'(onCurve), int'(v.expOn));
        checkOutput({v.name, " range_err hold"}, int'(rangeErr), int'(v.expErr));
    endtask

    initial begin
        vec_t vecs[$];
        int   lat;
        int   sawDone;
        logic bAcc;

        checks = 0;
        fails  = 0;
        rst    = 1'b1;
        start  = 1'b0;
        pubX   = '0;
        pubY   = '0;

        // Known points and boundaries, expectations written out by hand.
        vecs.push_back('{"G",           GX,     GY,          1'b1, 1'b0, FULL_LAT});
        vecs.push_back('{"G y+1",       GX,     GY + 256'd1, 1'b0, 1'b0, FULL_LAT});
        vecs.push_back('{"-G",          GX,     P - GY,      1'b1, 1'b0, FULL_LAT});
        vecs.push_back('{"x=p",         P,      GY,          1'b0, 1'b1, REJ_LAT});
        vecs.push_back('{"zero key",    256'd0, 256'd0,      1'b0, 1'b1, REJ_LAT});
        vecs.push_back('{"y=p",         GX,     P,           1'b0, 1'b1, REJ_LAT});
        vecs.push_back('{"x=0 y=1",     256'd0, 256'd1,      1'b0, 1'b0, FULL_LAT});
        vecs.push_back('{"x=max",       '1,     GY,          1'b0, 1'b1, REJ_LAT});
        // Model-judged points: an endomorphism image of G plus random ones.
        vecs.push_back(modelVec("beta*Gx", mulModP(BETA, GX), GY));
        vecs.push_back(modelVec("rand x>=p", P + 256'($urandom_range(0, 900)), rand256() >> 1));
        for (int i = 0; i < 3; i++) vecs.push_back(modelVec("rand", rand256() >> 1, rand256() >> 1));

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset on_curve", int'(onCurve), 0);
        checkOutput("reset range_err", int'(rangeErr), 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) runVector(vecs[i]);

        // Restart attempt with x=p at E100 during the G check is ignored.
        @(negedge clk);
        pubX  = GX;
        pubY  = GY;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = -1;
        for (int i = 1; i <= FULL_LAT + 20; i++) begin
            if (i == 100) begin
                start = 1'b1;
                pubX  = P;
            end
            @(posedge clk);
            #1;
            if (i == 100) start = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
        end
        checkOutput("restart ignored latency", lat, FULL_LAT);
        checkOutput("restart ignored on_curve", int'(onCurve), 1);
        checkOutput("restart ignored range_err", int'(rangeErr), 0);
        repeat (2) @(posedge clk);

        // Reset at E300 during the G check aborts it.
        @(negedge clk);
        pubX  = GX;
        pubY  = GY;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i < 300; i++) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("midreset busy", int'(busy), 0);
        checkOutput("midreset done", int'(done), 0);
        checkOutput("midreset on_curve", int'(onCurve), 0);
        checkOutput("midreset range_err", int'(rangeErr), 0);
        sawDone = 0;
        for (int i = 0; i < 800; i++) begin
            @(posedge clk);
            #1;
            if (done) sawDone = 1;
        end
        checkOutput("midreset no done", sawDone, 0);
        applyStimulus(GX, GY, lat, bAcc);
        checkOutput("post-reset G latency", lat, FULL_LAT);
        checkOutput("post-reset G on_curve", int'(onCurve), 1);
        repeat (2) @(posedge clk);

        // Reset wins over start on the same edge.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        pubX  = GX;
        pubY  = GY;
        @(posedge clk);
        #1;
        checkOutput("rst priority busy", int'(busy), 0);
        rst   = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst priority idle", int'(busy), 0);

        // Back-to-back: start raised in the done cycle, next done 772 edges later.
        applyStimulus(GX, GY, lat, bAcc);
        checkOutput("b2b first latency", lat, FULL_LAT);
        checkOutput("b2b first on_curve", int'(onCurve), 1);
        pubX  = GX;
        pubY  = GY + 256'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("b2b busy held", int'(busy), 1);
        checkOutput("b2b on_curve cleared", int'(onCurve), 0);
        waitDone(FULL_LAT + 20, lat);
        checkOutput("b2b done period", (lat < 0) ? -1 : lat + 1, FULL_LAT + 1);
        checkOutput("b2b second on_curve", int'(onCurve), 0);
        checkOutput("b2b second range_err", int'(rangeErr), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
